// File: rtl/ifetch_unit.sv
// ifetch_unit: owns the fetch PC, issues in-order imem word requests and buffers {pc, word}
// pairs for the decoder. Define IFETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_addr_o,
   input  logic        imem_resp_valid_i,
   input  logic [31:0] imem_resp_data_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        ins_valid_o,
   output logic [31:0] ins_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   input  logic        id_ready_i,
   output logic        trap_o
);
   localparam int unsigned   AW      = $clog2(FIFO_DEPTH);
   localparam int unsigned   CW      = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic          trap_q, trap_d;
   logic [31:0]   ins_mem_q [FIFO_DEPTH];
   logic [31:0]   pc_mem_q  [FIFO_DEPTH];

   logic [31:0]   redirect_tgt;
   logic          misaligned;
   logic [CW:0]   occupancy;
   logic          req_hs, push, pop;

   assign redirect_tgt = redirect_pc_i & 32'hFFFF_FFFC;
`ifdef IFETCH_MISALIGN_TRAP_EN
   assign misaligned = |redirect_pc_i[1:0];
`else
   assign misaligned = 1'b0;
`endif

   // In-flight words count against FIFO space so every response always has a slot.
   assign occupancy        = {1'b0, inflight_q} + {1'b0, count_q};
   assign imem_req_valid_o = rst_n && !redirect_i && !trap_q && (occupancy < {1'b0, DEPTH_C});
   assign imem_addr_o      = fetch_pc_q;
   assign req_hs           = imem_req_valid_o && imem_req_ready_i;

   assign ins_valid_o = rst_n && (count_q != '0);
   assign ins_o       = ins_valid_o ? ins_mem_q[rd_ptr_q] : '0;
   assign pc_o        = ins_valid_o ? pc_mem_q[rd_ptr_q] : '0;
   assign pc_plus4_o  = ins_valid_o ? pc_mem_q[rd_ptr_q] + 32'd4 : '0;
   assign trap_o      = rst_n && trap_q;

   assign push = imem_resp_valid_i && (discard_q == '0) && !trap_q && !redirect_i;
   assign pop  = ins_valid_o && id_ready_i && !redirect_i;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      inflight_d = inflight_q + CW'(req_hs) - CW'(imem_resp_valid_i);
      discard_d  = discard_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      trap_d     = trap_q;
      if (redirect_i) begin
         // Words still owed by memory after this cycle all belong to the old path.
         fetch_pc_d = redirect_tgt;
         resp_pc_d  = redirect_tgt;
         discard_d  = inflight_q - CW'(imem_resp_valid_i);
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         trap_d     = misaligned;
      end else begin
         if (req_hs) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (imem_resp_valid_i && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + 32'd4;
            wr_ptr_d  = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         trap_q     <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         trap_q     <= trap_d;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push) begin
         ins_mem_q[wr_ptr_q] <= imem_resp_data_i;
         pc_mem_q[wr_ptr_q]  <= resp_pc_q;
      end
   end

   assert property (@(posedge sys_clk) disable iff (!rst_n) !(push && (count_q == DEPTH_C)));

endmodule
